// File: rtl/wbslave_mailbox.sv
// Wishbone classic slave: 16-word register file, a mailbox data register with
// an interrupt, and a write-1-to-clear status register. One transfer per two cycles.

`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef SELECT_WIDTH
`define SELECT_WIDTH 4
`endif

module wbslave_mailbox #(
  parameter int          aw           = `ADDRESS_WIDTH - 1,
  parameter int          dw           = `DATA_WIDTH - 1,
  parameter int          sw           = `SELECT_WIDTH - 1,
  parameter logic [aw:0] mbox_address = 8'hFF,
  parameter logic [aw:0] stat_address = 8'hFE
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [aw:0] ADR_I,
  input  logic [sw:0] SEL_I,
  input  logic [dw:0] DAT_I,
  output logic [dw:0] DAT_O,
  output logic        ACK_O,
  output logic        ERR_O,
  output logic        INTR_O
);

  // Handshake: a request is CYC_I & STB_I sampled high in IDLE; exactly one
  // cycle later ACK_O (mapped) or ERR_O (unmapped) is high for one cycle.
  // The bus is not looked at while in RESP.
  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t      r_state;
  logic        r_ack;
  logic        r_err;
  logic        r_pend;
  logic        r_ovf;
  logic [dw:0] r_dat_o;
  logic [dw:0] r_mbox;
  logic [dw:0] r_rf [16];

  logic        w_req;
  logic        w_is_rf;
  logic        w_is_mbox;
  logic        w_is_stat;
  logic        w_mapped;
  logic        w_wr_en;
  logic [dw:0] w_stat;
  logic [dw:0] w_rd_data;
  logic        w_unused_sel;

  assign w_req     = CYC_I & STB_I;
  assign w_is_rf   = (ADR_I[aw:4] == '0);
  assign w_is_mbox = (ADR_I == mbox_address);
  assign w_is_stat = (ADR_I == stat_address);
  assign w_mapped  = w_is_rf | w_is_mbox | w_is_stat;
  assign w_wr_en   = WE_I & SEL_I[0];
  assign w_unused_sel = ^SEL_I;

  always_comb begin
    w_stat    = '0;
    w_stat[0] = r_pend;
    w_stat[1] = r_ovf;
  end

  always_comb begin
    w_rd_data = '0;
    if (w_is_rf)
      w_rd_data = r_rf[ADR_I[3:0]];
    else if (w_is_mbox)
      w_rd_data = r_mbox;
    else if (w_is_stat)
      w_rd_data = w_stat;
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_state <= IDLE;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_pend  <= 1'b0;
      r_ovf   <= 1'b0;
      r_dat_o <= '0;
      r_mbox  <= '0;
      for (int i = 0; i < 16; i++)
        r_rf[i] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_state <= RESP;
            r_ack   <= w_mapped;
            r_err   <= ~w_mapped;
            if (w_mapped && w_wr_en) begin
              if (w_is_rf)
                r_rf[ADR_I[3:0]] <= DAT_I;
              if (w_is_mbox) begin
                r_mbox <= DAT_I;
                r_pend <= 1'b1;
                if (r_pend)
                  r_ovf <= 1'b1;
              end
              if (w_is_stat && DAT_I[1])
                r_ovf <= 1'b0;
            end else if (w_mapped && !WE_I) begin
              r_dat_o <= w_rd_data;
              // Reading the data register consumes the message.
              if (w_is_mbox)
                r_pend <= 1'b0;
            end
          end
        end
        RESP: begin
          r_state <= IDLE;
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

  assign DAT_O  = r_dat_o;
  assign ACK_O  = r_ack;
  assign ERR_O  = r_err;
  assign INTR_O = r_pend;

endmodule

// File: doc/wbslave_mailbox.md
WBSLAVE_MAILBOX -- requirements
Module: wbslave_mailbox

Interface
REQ-001 Parameters SHALL be: aw, default `address_width-1`, address MSB index; dw, default `data_width-1`, data MSB index; sw, default `select_width-1`, select MSB index; mbox_address, default 8'hFF, mailbox data register address; stat_address, default 8'hFE, mailbox status register address.
REQ-002 Ports SHALL be, in order: CLK_I input 1 system clock; RST_I input 1 asynchronous active-low reset; CYC_I input 1 bus cycle valid; STB_I input 1 strobe; WE_I input 1 write enable; ADR_I input aw+1 address; SEL_I input sw+1 byte select; DAT_I input dw+1 write data; DAT_O output dw+1 read data; ACK_O output 1 normal termination; ERR_O output 1 error termination; INTR_O output 1 mailbox interrupt.
REQ-003 The module SHALL have one clock (CLK_I) and SHALL use asynchronous active-low reset on RST_I; all other logic is synchronous to posedge CLK_I.
REQ-004 All outputs SHALL be driven from registers; no tri-state values are driven.

Function
REQ-005 Address map SHALL be: 0x00-0x0F register file, 16 x (dw+1) bits, R/W; stat_address status, R/W1C; mbox_address mailbox, R/W; all other addresses unmapped.
REQ-006 FSM states SHALL be IDLE and RESP; IDLE -> RESP when CYC_I & STB_I sampled high; RESP -> IDLE unconditionally after one cycle; the bus is ignored in RESP.
REQ-007 At the IDLE-cycle edge accepting a request, the block SHALL register ACK_O=1 (mapped address) or ERR_O=1 (unmapped), never both, so termination appears exactly one cycle after the request is sampled.
REQ-008 ACK_O and ERR_O SHALL be one-cycle pulses, cleared at the RESP-to-IDLE edge; maximum throughput is one transfer per two cycles.
REQ-009 A master holding CYC_I & STB_I high after termination SHALL be treated as a new transfer accepted in the following IDLE cycle.
REQ-010 Writes (WE_I=1) SHALL commit at the accepting edge only when SEL_I[0]=1; with SEL_I[0]=0 no state changes, but ACK_O is still given for mapped addresses.
REQ-011 Reads SHALL load DAT_O at the accepting edge with the addressed content; DAT_O SHALL hold its value until the next read; unmapped reads and all writes leave DAT_O unchanged.
REQ-012 Status register layout SHALL be: bit0 PEND (read-only, equals INTR_O); bit1 OVF; other bits read 0. Writing 1 to bit1 clears OVF; writing 0 has no effect.
REQ-013 A write to mbox_address SHALL store DAT_I, set PEND/INTR_O at the same edge, and set OVF if PEND was already 1.
REQ-014 A read of mbox_address SHALL return the stored value and clear PEND/INTR_O at the same edge; reading the status register SHALL NOT clear anything.
REQ-015 If CYC_I or STB_I drops during RESP, the committed write or read SHALL stand and ACK_O/ERR_O SHALL still be cleared at the next edge (no rollback).
REQ-016 Unmapped accesses SHALL NOT modify any storage and SHALL NOT affect INTR_O.

Reset
REQ-017 While RST_I=0, and immediately on its assertion regardless of clock, the block SHALL force: state IDLE, ACK_O=0, ERR_O=0, INTR_O=0, DAT_O=0, OVF=0, mailbox=0, all register-file words=0.
REQ-018 Reset asserted mid-transfer SHALL abort it with no termination pulse; the first request after RST_I rises SHALL be sampled no earlier than the first posedge with RST_I=1.

Verification
REQ-019 Write 0x5A to 0x03 with SEL=1, then read 0x03 -> each ACK_O pulse is 1 cycle, 1 cycle after STB; read DAT_O=0x5A; ERR_O stays 0.
REQ-020 Read 0x40 -> ERR_O=1 for one cycle, ACK_O=0, DAT_O unchanged; then write 0x40 -> ERR_O pulse, register file unchanged.
REQ-021 Write 0x11 to 0xFF -> INTR_O=1; write 0x22 to 0xFF -> status reads 0x03; read 0xFF -> DAT_O=0x22, INTR_O=0; status reads 0x02; write 0x02 to 0xFE -> status reads 0x00.
REQ-022 Write 0x77 to 0x05 with SEL=0 -> ACK_O pulse; read 0x05 returns 0x00.
REQ-023 STB/CYC held high for 6 cycles with alternating reads of 0x00/0x01 -> exactly 3 ACK_O pulses, 2 cycles apart.
REQ-024 Assert RST_I=0 between clock edges during RESP after a mailbox write -> ACK_O, INTR_O and DAT_O go to 0 without waiting for a clock edge; a subsequent read of 0xFF returns 0x00.
